// File: rtl/silly_vec_driver.sv
// Stimulus/checker stage for the 3-input `silly` block: sweeps {a,b,c} through
// 0..7, samples y at the end of each hold window and scores it against EXPECTED.
module silly_vec_driver #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter logic [7:0]  EXPECTED    = 8'h31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_mask
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("silly_vec_driver: HOLD_CYCLES must be in 1..255");
    end

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q;
    logic [2:0] vec_q;
    logic [7:0] hold_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] err_q;
    logic [7:0] mask_q;

    logic       miss_d;
    logic [3:0] err_d;
    logic [7:0] mask_d;

    // Score of the vector currently on the bus, committed only at the sampling edge.
    always_comb begin
        miss_d = (y != EXPECTED[vec_q]);
        err_d  = err_q + {3'b000, miss_d};
        mask_d = mask_q | (miss_d ? (8'h01 << vec_q) : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= 3'd0;
            hold_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 4'd0;
            mask_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        vec_q   <= 3'd0;
                        hold_q  <= 8'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= 4'd0;
                        mask_q  <= 8'h00;
                    end
                end
                RUN: begin
                    if (hold_q == HOLD_LAST) begin
                        err_q  <= err_d;
                        mask_q <= mask_d;
                        hold_q <= 8'd0;
                        // pass uses err_d so the final vector's result is included.
                        if (vec_q == 3'd7) begin
                            state_q <= DONE;
                            vec_q   <= 3'd0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == 4'd0);
                        end else begin
                            vec_q <= vec_q + 3'd1;
                        end
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a         = vec_q[2];
    assign b         = vec_q[1];
    assign c         = vec_q[0];
    assign vec_idx   = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_silly_vec_driver.sv
// Directed bench for silly_vec_driver: two instances (HOLD_CYCLES 1 and 3) driven
// by a truth-table model of the `silly` block under test.
module tb_silly_vec_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start1, start3;
    logic [7:0] tt1, tt3;
    logic       y1, y3;
    logic       a1, b1, c1, a3, b3, c3;
    logic [2:0] vec1, vec3;
    logic       busy1, busy3, done1, done3, pass1, pass3;
    logic [3:0] err1, err3;
    logic [7:0] mask1, mask3;

    int n_tests = 0;
    int n_fail  = 0;

    assign y1 = tt1[{a1, b1, c1}];
    assign y3 = tt3[{a3, b3, c3}];

    silly_vec_driver #(.HOLD_CYCLES(1), .EXPECTED(8'h31)) u_h1 (
        .clk(clk), .reset(reset), .start(start1), .y(y1),
        .a(a1), .b(b1), .c(c1), .vec_idx(vec1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_mask(mask1)
    );

    silly_vec_driver #(.HOLD_CYCLES(3), .EXPECTED(8'h31)) u_h3 (
        .clk(clk), .reset(reset), .start(start3), .y(y3),
        .a(a3), .b(b3), .c(c3), .vec_idx(vec3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_mask(mask3)
    );

    typedef struct {
        logic [7:0] tt;
        logic [3:0] err;
        logic [7:0] mask;
        logic       pass;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int inst, input logic e_busy,
                             input logic e_done, input logic e_pass, input logic [3:0] e_err,
                             input logic [7:0] e_mask, input logic [2:0] e_vec);
        if (inst == 1) begin
            check({tag, ".busy"}, 32'(busy1), 32'(e_busy));
            check({tag, ".done"}, 32'(done1), 32'(e_done));
            check({tag, ".pass"}, 32'(pass1), 32'(e_pass));
            check({tag, ".err"},  32'(err1),  32'(e_err));
            check({tag, ".mask"}, 32'(mask1), 32'(e_mask));
            check({tag, ".vec"},  32'(vec1),  32'(e_vec));
            check({tag, ".abc"},  32'({a1, b1, c1}), 32'(e_vec));
        end else begin
            check({tag, ".busy"}, 32'(busy3), 32'(e_busy));
            check({tag, ".done"}, 32'(done3), 32'(e_done));
            check({tag, ".pass"}, 32'(pass3), 32'(e_pass));
            check({tag, ".err"},  32'(err3),  32'(e_err));
            check({tag, ".mask"}, 32'(mask3), 32'(e_mask));
            check({tag, ".vec"},  32'(vec3),  32'(e_vec));
            check({tag, ".abc"},  32'({a3, b3, c3}), 32'(e_vec));
        end
    endtask

    // One full HOLD_CYCLES=1 run with y taken from truth table tt.
    task automatic run_h1(input string tag, input vec_t r);
        tt1    = r.tt;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check_out({tag, ".start"}, 1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check({tag, ".step_vec"},  32'(vec1), 32'(i));
            check({tag, ".step_done"}, 32'(done1), 32'd0);
        end
        tick();
        check_out({tag, ".end"}, 1, 1'b0, 1'b1, r.pass, r.err, r.mask, 3'd0);
    endtask

    initial begin
        tbl[0] = '{tt: 8'h31, err: 4'd0, mask: 8'h00, pass: 1'b1};
        tbl[1] = '{tt: 8'hCE, err: 4'd8, mask: 8'hFF, pass: 1'b0};
        tbl[2] = '{tt: 8'h00, err: 4'd3, mask: 8'h31, pass: 1'b0};
        tbl[3] = '{tt: 8'h31, err: 4'd0, mask: 8'h00, pass: 1'b1};
        tbl[4] = '{tt: 8'hFF, err: 4'd5, mask: 8'hCE, pass: 1'b0};
        tbl[5] = '{tt: 8'h71, err: 4'd1, mask: 8'h40, pass: 1'b0};
        tbl[6] = '{tt: 8'h30, err: 4'd1, mask: 8'h01, pass: 1'b0};

        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        tt1    = 8'h31;
        tt3    = 8'h31;
        tick();
        tick();
        check_out("reset_h1", 1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0);
        check_out("reset_h3", 3, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0);
        reset = 1'b0;
        tick();

        // Row 3 follows the stuck-at-0 row: restart from DONE must clear old results.
        for (int r = 0; r < 7; r++) begin
            run_h1($sformatf("row%0d", r), tbl[r]);
            tick();
        end

        // HOLD_CYCLES=3: each vector held three cycles, done 24 cycles after start.
        tt3    = 8'h31;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check_out("h3.start", 3, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0);
        for (int t = 1; t < 24; t++) begin
            tick();
            check("h3.vec",  32'(vec3),  32'(t / 3));
            check("h3.done", 32'(done3), 32'd0);
        end
        tick();
        check_out("h3.end", 3, 1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 3'd0);

        tt3    = 8'h00;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (23) tick();
        check("h3s0.done_early", 32'(done3), 32'd0);
        tick();
        check_out("h3s0.end", 3, 1'b0, 1'b1, 1'b0, 4'd3, 8'h31, 3'd0);

        // start re-pulsed at vector 2 must be ignored.
        tt1    = 8'h31;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        check("restart.vec2", 32'(vec1), 32'd2);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check_out("restart.ignored", 1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 3'd3);
        repeat (4) tick();
        check("restart.not_done", 32'(done1), 32'd0);
        tick();
        check_out("restart.end", 1, 1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 3'd0);

        // Reset at vector 4 of a faulty run aborts it with nothing retained.
        tick();
        tt1    = 8'h00;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (4) tick();
        check("abort.vec4", 32'(vec1), 32'd4);
        reset = 1'b1;
        tick();
        check_out("abort.reset", 1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0);
        reset = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            check("abort.no_done", 32'(done1), 32'd0);
            check("abort.no_busy", 32'(busy1), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/silly_vec_driver.md
Name: silly_vec_driver

Overview:
Self-checking stimulus stage that sits directly upstream of the 3-input `silly` combinational block. On a start pulse it drives all eight {a,b,c} combinations in ascending order and samples `silly`'s y output at the end of each vector. It compares each sample against a parameterised truth table and reports a mismatch count, a per-vector fail mask, and a pass flag. It replaces hand-written stimulus sequences with a reusable, synthesizable checker.

Parameters:
HOLD_CYCLES, 1, clock cycles each vector is held before y is sampled; legal range 1..255.
EXPECTED, 8'h31, expected y per vector; bit i = expected y for {a,b,c}=i.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin a run; sampled on rising edge; ignored while busy=1.
y  input  1  output of `silly` under test.
a  output  1  stimulus MSB, equal to vec_idx[2].
b  output  1  stimulus, equal to vec_idx[1].
c  output  1  stimulus LSB, equal to vec_idx[0].
vec_idx  output  3  index of the vector currently driven.
busy  output  1  high while a run is in progress.
done  output  1  high from run completion until the next start or reset.
pass  output  1  done && err_count==0.
err_count  output  4  number of mismatching vectors, 0..8.
fail_mask  output  8  bit i set if vector i mismatched.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- All outputs are registered.
- Reset values: a=b=c=0, vec_idx=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, hold counter=0, state=IDLE.
- Reset asserted mid-run aborts the run. All values return to reset values at that edge, and no partial results are retained.
- State IDLE: wait for start.
- start=1 at edge k, in IDLE or DONE:
  - at edge k: state=RUN, busy=1, done=0, pass=0, err_count=0, fail_mask=0, vec_idx=0, hold counter=0.
- State RUN: hold counter increments every cycle.
- At the edge where hold counter==HOLD_CYCLES-1, y is sampled:
  - if y != EXPECTED[vec_idx]: err_count+=1 and fail_mask[vec_idx]=1.
  - if vec_idx<7: vec_idx+=1 and hold counter=0.
  - if vec_idx==7: state=DONE, busy=0, done=1, pass=(final err_count==0), vec_idx=0 (a=b=c=0).
- The err_count and pass updates include the mismatch from the final sample in the same cycle.
- Timing:
  - vector i is driven from edge k+i*HOLD_CYCLES and sampled at edge k+(i+1)*HOLD_CYCLES.
  - done rises at edge k+8*HOLD_CYCLES.
  - with HOLD_CYCLES=1, each vector lasts one cycle and done rises 8 cycles after start.
- Settling: y must settle within the hold window. There is no internal synchroniser, and y is compared as sampled at the sampling edge.
- State DONE: done, pass, err_count and fail_mask hold stable. start restarts a run exactly as from IDLE.
- start while busy=1 has no effect.
- Simultaneous events: reset has priority over start. start held high continuously restarts a run at each DONE entry's following edge, because DONE accepts start.
- Width rules:
  - err_count is 4 bits, so the maximum of 8 never overflows.
  - hold counter is 8 bits and compares against HOLD_CYCLES-1.
  - HOLD_CYCLES=0 is illegal and flagged by an elaboration-time assertion.
- No combinational path from y or start to any output.

Test Plan:
1. HOLD_CYCLES=1, y driven by a correct `silly` (truth table 8'h31), start pulse at cycle 0 -> a,b,c step 000..111 one per cycle; done=1 at cycle 8; err_count=0, fail_mask=8'h00, pass=1, busy=0.
2. y tied to the inverse of the correct model -> err_count=8, fail_mask=8'hFF, pass=0.
3. y stuck at 0 -> mismatches on vectors 0, 4 and 5: err_count=3, fail_mask=8'h31, pass=0.
4. HOLD_CYCLES=3 with a correct model -> each {a,b,c} value held 3 cycles; done rises 24 cycles after start; pass=1.
5. start re-pulsed at vector 2 mid-run -> ignored, and the run completes at the original cycle. Then reset asserted at vector 4 of a new run -> at the next edge all outputs equal reset values and done never asserts.
6. From DONE with err_count=3, pulse start with a correct model -> at the start edge done=0, err_count=0, fail_mask=0; the run finishes with pass=1.
